// File: rtl/pulse_seq_pkg.sv
// Shared types and defaults for the pulse step sequencer.
// Holds the FSM state enum, the table entry struct and a duration helper.
package pulse_seq_pkg;

    localparam int SEQ_DEPTH = 16;
    localparam int SEQ_AW    = $clog2(SEQ_DEPTH);
    localparam int SEQ_DUR_W = 24;

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        PAUSE
    } state_t;

    typedef struct packed {
        logic [31:0]          ctrl;
        logic [31:0]          duty;
        logic [SEQ_DUR_W-1:0] dur;
    } step_t;

    // A zero-length step still occupies one cycle.
    function automatic logic [SEQ_DUR_W-1:0] eff_dur(
        input logic [SEQ_DUR_W-1:0] d
    );
        return (d == '0) ? SEQ_DUR_W'(1) : d;
    endfunction

endpackage

// File: rtl/pulse_step_table.sv
// Step table: DEPTH entries, one synchronous write port, one combinational
// read port. Ports: clk, wr_en/wr_addr/wr_data, rd_addr -> rd_data.
module pulse_step_table
    import pulse_seq_pkg::*;
#(
    parameter int DEPTH = SEQ_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  step_t         wr_data,
    input  logic [AW-1:0] rd_addr,
    output step_t         rd_data
);

    // Not reset: contents survive rst and are owned by the host.
    step_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Same-cycle write to rd_addr is seen only after the edge (old data).
    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pulse_sequencer.sv
// Step sequencer feeding ctrl/duty words to the pulse generator.
// Ports: table write (wr_*), control (start/stop/pause/loop_en/last_idx),
// outputs ctrl_out/duty_out/step_idx/busy/done, all registered.
module pulse_sequencer
    import pulse_seq_pkg::*;
#(
    parameter int DEPTH = SEQ_DEPTH,
    parameter int AW    = $clog2(DEPTH),
    parameter int DUR_W = SEQ_DUR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [31:0]      wr_ctrl,
    input  logic [31:0]      wr_duty,
    input  logic [DUR_W-1:0] wr_dur,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             loop_en,
    input  logic [AW-1:0]    last_idx,
    output logic [31:0]      ctrl_out,
    output logic [31:0]      duty_out,
    output logic [AW-1:0]    step_idx,
    output logic             busy,
    output logic             done
);

    state_t            state;
    logic [DUR_W-1:0]  cnt;
    logic [AW-1:0]     last;
    logic [31:0]       cur_ctrl;
    logic [AW-1:0]     rd_addr;
    step_t             rd;
    step_t             wr_data;

    assign wr_data = '{ctrl: wr_ctrl, duty: wr_duty, dur: wr_dur};

    pulse_step_table #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_table (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd)
    );

    // The read port always points at the entry that would be loaded next:
    // entry 0 from IDLE or at the last step (wrap), else the following one.
    always_comb begin
        rd_addr = '0;
        if (state == PLAY && step_idx != last) begin
            rd_addr = step_idx + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            last     <= '0;
            step_idx <= '0;
            ctrl_out <= '0;
            duty_out <= '0;
            cur_ctrl <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start && !stop) begin
                        state    <= PLAY;
                        last     <= last_idx;
                        step_idx <= '0;
                        ctrl_out <= rd.ctrl;
                        cur_ctrl <= rd.ctrl;
                        duty_out <= rd.duty;
                        cnt      <= eff_dur(rd.dur);
                        busy     <= 1'b1;
                    end
                end
                PLAY: begin
                    if (stop) begin
                        state    <= IDLE;
                        ctrl_out <= '0;
                        duty_out <= '0;
                        busy     <= 1'b0;
                    end else if (pause) begin
                        // Count is held, so a pause on the terminal
                        // cycle defers the advance until resume.
                        state    <= PAUSE;
                        ctrl_out <= '0;
                    end else if (cnt != DUR_W'(1)) begin
                        cnt <= cnt - DUR_W'(1);
                    end else if (step_idx != last || loop_en) begin
                        step_idx <= rd_addr;
                        ctrl_out <= rd.ctrl;
                        cur_ctrl <= rd.ctrl;
                        duty_out <= rd.duty;
                        cnt      <= eff_dur(rd.dur);
                    end else begin
                        state    <= IDLE;
                        ctrl_out <= '0;
                        duty_out <= '0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end
                end
                PAUSE: begin
                    if (stop) begin
                        state    <= IDLE;
                        ctrl_out <= '0;
                        duty_out <= '0;
                        busy     <= 1'b0;
                    end else if (!pause) begin
                        // Restore from the stored copy so table edits
                        // made during the pause do not leak in.
                        state    <= PLAY;
                        ctrl_out <= cur_ctrl;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_sequencer.sv
// Scoreboard bench for pulse_sequencer: a behavioural model predicts the
// outputs after each clock edge; a monitor pops and compares them.
module tb_pulse_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_ctrl;
    logic [31:0] wr_duty;
    logic [23:0] wr_dur;
    logic        start;
    logic        stop;
    logic        pause;
    logic        loop_en;
    logic [3:0]  last_idx;
    logic [31:0] ctrl_out;
    logic [31:0] duty_out;
    logic [3:0]  step_idx;
    logic        busy;
    logic        done;

    pulse_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_ctrl  (wr_ctrl),
        .wr_duty  (wr_duty),
        .wr_dur   (wr_dur),
        .start    (start),
        .stop     (stop),
        .pause    (pause),
        .loop_en  (loop_en),
        .last_idx (last_idx),
        .ctrl_out (ctrl_out),
        .duty_out (duty_out),
        .step_idx (step_idx),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ctrl;
        logic [31:0] duty;
        int          idx;
        logic        busy;
        logic        done;
        logic        chk_idx;
    } exp_t;

    exp_t exp_q [$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Behavioural model: what the generator should see, by playback mode.
    localparam int M_IDLE = 0, M_RUN = 1, M_HOLD = 2;
    logic [31:0] t_ctrl [16];
    logic [31:0] t_duty [16];
    int          t_dur  [16];
    int          m_mode, m_idx, m_last, m_rem;
    logic [31:0] m_ctrl, m_duty;
    logic        m_done;

    function automatic void begin_step(int k);
        m_idx  = k;
        m_ctrl = t_ctrl[k];
        m_duty = t_duty[k];
        m_rem  = (t_dur[k] == 0) ? 1 : t_dur[k];
    endfunction

    function automatic void model_step();
        m_done = 1'b0;
        if (rst) begin
            m_mode = M_IDLE;
            m_idx  = 0;
            m_last = 0;
            m_rem  = 0;
        end else if (m_mode == M_IDLE) begin
            if (start && !stop) begin
                m_mode = M_RUN;
                m_last = int'(last_idx);
                begin_step(0);
            end
        end else if (m_mode == M_RUN) begin
            if (stop) m_mode = M_IDLE;
            else if (pause) m_mode = M_HOLD;
            else if (m_rem > 1) m_rem--;
            else if (m_idx < m_last) begin_step(m_idx + 1);
            else if (loop_en) begin_step(0);
            else begin
                m_mode = M_IDLE;
                m_done = 1'b1;
            end
        end else begin
            if (stop) m_mode = M_IDLE;
            else if (!pause) m_mode = M_RUN;
        end
        // Table write lands at the same edge, after any read above.
        if (wr_en) begin
            t_ctrl[wr_addr] = wr_ctrl;
            t_duty[wr_addr] = wr_duty;
            t_dur[wr_addr]  = int'(wr_dur);
        end
    endfunction

    task automatic tick();
        exp_t e;
        model_step();
        e.ctrl    = (m_mode == M_RUN) ? m_ctrl : 32'h0;
        e.duty    = (m_mode != M_IDLE) ? m_duty : 32'h0;
        e.idx     = m_idx;
        e.busy    = (m_mode != M_IDLE);
        e.done    = m_done;
        e.chk_idx = (m_mode != M_IDLE) || rst;
        exp_q.push_back(e);
        @(negedge clk);
        wr_en = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic wr(int a, logic [31:0] c, logic [31:0] d, int n);
        wr_en   = 1'b1;
        wr_addr = 4'(a);
        wr_ctrl = c;
        wr_duty = d;
        wr_dur  = 24'(n);
        tick();
    endtask

    task automatic run(int n);
        repeat (n) tick();
    endtask

    // Monitor: every cycle the DUT presents a fresh output set.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (ctrl_out !== e.ctrl || duty_out !== e.duty ||
                    busy !== e.busy || done !== e.done ||
                    (e.chk_idx && step_idx !== 4'(e.idx))) begin
                    errors++;
                    $display("FAIL cyc%0d: got ctrl=%h duty=%h idx=%0d busy=%b done=%b, expected ctrl=%h duty=%h idx=%0d busy=%b done=%b",
                             cyc, ctrl_out, duty_out, step_idx, busy, done,
                             e.ctrl, e.duty, e.idx, e.busy, e.done);
                end
            end
        end
    end

    initial begin
        int guard;
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_ctrl = '0;
        wr_duty = '0; wr_dur = '0; start = 1'b0; stop = 1'b0;
        pause = 1'b0; loop_en = 1'b0; last_idx = '0;
        for (int i = 0; i < 16; i++) begin
            t_ctrl[i] = '0; t_duty[i] = '0; t_dur[i] = 0;
        end
        @(negedge clk);

        // Preload under reset while start is held: nothing may play.
        for (int i = 0; i < 16; i++) begin
            start = 1'b1;
            wr(i, 32'h1000 + i, 32'h2000_0000 + i, i % 4);
        end
        start = 1'b1;
        run(1);
        rst = 1'b0;
        run(3);

        // Three-step sequence, no loop.
        wr(0, 32'h100, 32'h8000_0000, 3);
        wr(1, 32'h200, 32'h4000_0000, 5);
        wr(2, 32'h300, 32'hC000_0000, 1);
        last_idx = 4'd2; loop_en = 1'b0; start = 1'b1;
        run(14);

        // Looping, then drop loop_en mid-pass.
        loop_en = 1'b1; start = 1'b1;
        run(13);
        loop_en = 1'b0;
        run(12);

        // Pause inside step 1 with three cycles left.
        start = 1'b1;
        run(5);
        pause = 1'b1;
        run(4);
        pause = 1'b0;
        run(10);

        // Stop during step 1; then start+stop together in IDLE.
        start = 1'b1;
        run(5);
        stop = 1'b1;
        run(4);
        start = 1'b1; stop = 1'b1;
        run(3);

        // Zero-length step; edit entry 1 while it plays.
        wr(1, 32'h250, 32'h1111_0000, 0);
        wr(2, 32'h300, 32'hC000_0000, 3);
        loop_en = 1'b1; start = 1'b1;
        run(4);
        wr(2, 32'h350, 32'h2222_0000, 2);
        run(12);
        stop = 1'b1;
        run(2);

        // Randomized traffic.
        repeat (3000) begin
            wr_en   = ($urandom % 4) == 0;
            wr_addr = 4'($urandom % 16);
            wr_ctrl = $urandom;
            wr_duty = $urandom;
            wr_dur  = 24'($urandom % 5);
            start   = ($urandom % 6) == 0;
            stop    = ($urandom % 50) == 0;
            if (($urandom % 8) == 0) pause = ~pause;
            if (($urandom % 20) == 0) loop_en = ~loop_en;
            last_idx = 4'($urandom % 4);
            rst     = ($urandom % 600) == 0;
            tick();
        end
        rst = 1'b0; pause = 1'b0;

        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d pending, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
